// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle CPU control FSM.
// Contents:
//   state_e  : 4-bit state encoding
//   OP_*     : opcode values (IR[31:26])
//   SRCB_*   : ALUSrcB codes
//   PCSRC_*  : PCSrc codes
//   ALUOP_*  : ALUOp codes
//   ctrl_t   : packed control word driven to the Datapath
//   retires(): true for the states whose exit to FETCH retires an instruction
package multicycle_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_WB_R     = 4'd4,
    ST_EXEC_I   = 4'd5,
    ST_WB_I     = 4'd6,
    ST_MEM_ADDR = 4'd7,
    ST_MEM_RD   = 4'd8,
    ST_WB_M     = 4'd9,
    ST_MEM_WR   = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12,
    ST_ERROR    = 4'd13
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] SRCB_REG     = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  typedef struct packed {
    logic       select_ins;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       mem_write;
    logic       mem_to_reg;
    logic       beq;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       ir_write;
    logic       illegal;
  } ctrl_t;

  function automatic logic retires(input state_e s);
    return (s == ST_WB_R)  || (s == ST_WB_I)   || (s == ST_WB_M) ||
           (s == ST_MEM_WR) || (s == ST_BRANCH) || (s == ST_JUMP);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bus between the multicycle control FSM and the Datapath.
// Signals:
//   opcode, mem_ready         : Datapath -> controller
//   SelectIns .. ir_write     : controller -> Datapath control inputs
//   illegal                   : sticky error flag (unknown opcode / memory timeout)
//   instr_count [CNT_W]       : retired-instruction counter
//   state                     : current FSM state, for observation only
// Modports: master = controller, slave = Datapath side.
interface multicycle_ctrl_fsm_if
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic [5:0]       opcode;
  logic             mem_ready;
  logic             SelectIns;
  logic             RegWrite;
  logic             RegDst;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic             MemWrite;
  logic             MemtoReg;
  logic             BEQ;
  logic [1:0]       PCSrc;
  logic [1:0]       ALUOp;
  logic             pc_write;
  logic             ir_write;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;
  state_e           state;

  modport master (
    input  opcode, mem_ready,
    output SelectIns, RegWrite, RegDst, ALUSrcA, ALUSrcB, MemWrite, MemtoReg,
           BEQ, PCSrc, ALUOp, pc_write, ir_write, illegal, instr_count, state
  );

  modport slave (
    output opcode, mem_ready,
    input  SelectIns, RegWrite, RegDst, ALUSrcA, ALUSrcB, MemWrite, MemtoReg,
           BEQ, PCSrc, ALUOp, pc_write, ir_write, illegal, instr_count, state
  );

endinterface

// File: rtl/multicycle_ctrl_fsm_decode.sv
// Combinational state -> control-word decoder (Moore outputs).
// Ports:
//   i_state : current FSM state
//   o_ctrl  : control word; every field not named for a state is 0
module multicycle_ctrl_fsm_decode
  import multicycle_ctrl_fsm_pkg::*;
(
  input  state_e i_state,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      ST_FETCH: begin
        o_ctrl.select_ins = 1'b1;
        o_ctrl.ir_write   = 1'b1;
        o_ctrl.alu_src_a  = 1'b0;
        o_ctrl.alu_src_b  = SRCB_FOUR;
        o_ctrl.alu_op     = ALUOP_ADD;
        o_ctrl.pc_src     = PCSRC_ALU;
        o_ctrl.pc_write   = 1'b1;
      end
      ST_DECODE: begin
        // Branch target PC + (imm<<2) lands in ALUOut ahead of BRANCH
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = SRCB_IMM_SH2;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      ST_EXEC_R: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_REG;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_WB_R: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      ST_EXEC_I, ST_MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      ST_WB_I: begin
        o_ctrl.reg_write = 1'b1;
      end
      ST_WB_M: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        o_ctrl.mem_write = 1'b1;
      end
      ST_BRANCH: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_REG;
        o_ctrl.alu_op    = ALUOP_SUB;
        o_ctrl.beq       = 1'b1;
        o_ctrl.pc_src    = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        o_ctrl.pc_write = 1'b1;
        o_ctrl.pc_src   = PCSRC_JUMP;
      end
      ST_ERROR: begin
        o_ctrl.illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM sequencing the multicycle Datapath through
// fetch / decode / execute / memory / writeback.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : multicycle_ctrl_fsm_if.master (opcode/mem_ready in, controls out)
// Parameters:
//   CNT_W    : width of instr_count (wraps modulo 2^CNT_W)
//   WAIT_MAX : cycles of mem_ready=0 tolerated in MEM_RD/MEM_WR (1..255)
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | after reset, all outputs 0, one cycle
// FETCH     | IR <= imem, PC <= PC+4
// DECODE    | branch target into ALUOut, dispatch on opcode
// EXEC_R    | A funct B
// WB_R      | rd <= ALUOut
// EXEC_I    | A + sign-ext imm
// WB_I      | rt <= ALUOut
// MEM_ADDR  | effective address A + imm
// MEM_RD    | wait for read data (timeout -> ERROR)
// WB_M      | rt <= memory data
// MEM_WR    | write strobe held until accepted (timeout -> ERROR)
// BRANCH    | compare A-B, conditional PC <= ALUOut
// JUMP      | PC <= jump target
// ERROR     | illegal=1, exits only on reset
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_ctrl_fsm_if.master bus
);

  // Last tolerated count: the WAIT_MAX-th not-ready cycle times out.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_e           r_state;
  state_e           w_next;
  logic [7:0]       r_wait_cnt;
  logic [CNT_W-1:0] r_instr_count;
  logic             w_wait_last;
  ctrl_t            w_ctrl;

  assign w_wait_last = (r_wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = ST_FETCH;
      ST_FETCH:  w_next = ST_DECODE;
      ST_DECODE: begin
        case (bus.opcode)
          OP_R:         w_next = ST_EXEC_R;
          OP_ADDI:      w_next = ST_EXEC_I;
          OP_LW, OP_SW: w_next = ST_MEM_ADDR;
          OP_BEQ:       w_next = ST_BRANCH;
          OP_J:         w_next = ST_JUMP;
          default:      w_next = ST_ERROR;
        endcase
      end
      ST_EXEC_R:   w_next = ST_WB_R;
      ST_WB_R:     w_next = ST_FETCH;
      ST_EXEC_I:   w_next = ST_WB_I;
      ST_WB_I:     w_next = ST_FETCH;
      // Only LW and SW reach MEM_ADDR; IR is stable so opcode still selects.
      ST_MEM_ADDR: w_next = (bus.opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: begin
        // mem_ready on the last tolerated cycle still completes normally
        if (bus.mem_ready)    w_next = ST_WB_M;
        else if (w_wait_last) w_next = ST_ERROR;
      end
      ST_WB_M: w_next = ST_FETCH;
      ST_MEM_WR: begin
        if (bus.mem_ready)    w_next = ST_FETCH;
        else if (w_wait_last) w_next = ST_ERROR;
      end
      ST_BRANCH: w_next = ST_FETCH;
      ST_JUMP:   w_next = ST_FETCH;
      ST_ERROR:  w_next = ST_ERROR;
      default:   w_next = ST_ERROR;
    endcase
  end

  // Cleared while in MEM_ADDR so it is zero on entry to MEM_RD/MEM_WR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 8'd0;
    end else if (r_state == ST_MEM_ADDR) begin
      r_wait_cnt <= 8'd0;
    end else if (((r_state == ST_MEM_RD) || (r_state == ST_MEM_WR)) && !bus.mem_ready) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_count <= '0;
    end else if ((w_next == ST_FETCH) && retires(r_state)) begin
      r_instr_count <= r_instr_count + CNT_W'(1);
    end
  end

  multicycle_ctrl_fsm_decode u_decode (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  assign bus.SelectIns   = w_ctrl.select_ins;
  assign bus.RegWrite    = w_ctrl.reg_write;
  assign bus.RegDst      = w_ctrl.reg_dst;
  assign bus.ALUSrcA     = w_ctrl.alu_src_a;
  assign bus.ALUSrcB     = w_ctrl.alu_src_b;
  assign bus.MemWrite    = w_ctrl.mem_write;
  assign bus.MemtoReg    = w_ctrl.mem_to_reg;
  assign bus.BEQ         = w_ctrl.beq;
  assign bus.PCSrc       = w_ctrl.pc_src;
  assign bus.ALUOp       = w_ctrl.alu_op;
  assign bus.pc_write    = w_ctrl.pc_write;
  assign bus.ir_write    = w_ctrl.ir_write;
  assign bus.illegal     = w_ctrl.illegal;
  assign bus.instr_count = r_instr_count;
  assign bus.state       = r_state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;
  import multicycle_ctrl_fsm_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if #(.CNT_W(16)) bus  ();
  multicycle_ctrl_fsm_if #(.CNT_W(4))  bus2 ();

  multicycle_ctrl_fsm #(.CNT_W(16), .WAIT_MAX(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Narrow counter instance: exercises wrap-around without 65536 instructions
  multicycle_ctrl_fsm #(.CNT_W(4), .WAIT_MAX(15)) dut_wrap (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // {SelectIns,RegWrite,RegDst,ALUSrcA,ALUSrcB,MemWrite,MemtoReg,BEQ,PCSrc,ALUOp,pc_write,ir_write,illegal}
  function automatic logic [15:0] mk(input logic sel, input logic rw, input logic rd, input logic sa,
                                     input logic [1:0] sb, input logic mw, input logic m2r, input logic beq,
                                     input logic [1:0] pcs, input logic [1:0] aop, input logic pcw,
                                     input logic irw, input logic ill);
    return {sel, rw, rd, sa, sb, mw, m2r, beq, pcs, aop, pcw, irw, ill};
  endfunction

  function automatic logic [15:0] outs();
    return {bus.SelectIns, bus.RegWrite, bus.RegDst, bus.ALUSrcA, bus.ALUSrcB, bus.MemWrite,
            bus.MemtoReg, bus.BEQ, bus.PCSrc, bus.ALUOp, bus.pc_write, bus.ir_write, bus.illegal};
  endfunction

  function automatic logic [15:0] exp_ctrl(input state_e s);
    case (s)
      ST_FETCH:    return mk(1,0,0,0,2'd1,0,0,0,2'd0,2'd0,1,1,0);
      ST_DECODE:   return mk(0,0,0,0,2'd3,0,0,0,2'd0,2'd0,0,0,0);
      ST_EXEC_R:   return mk(0,0,0,1,2'd0,0,0,0,2'd0,2'd2,0,0,0);
      ST_WB_R:     return mk(0,1,1,0,2'd0,0,0,0,2'd0,2'd0,0,0,0);
      ST_EXEC_I:   return mk(0,0,0,1,2'd2,0,0,0,2'd0,2'd0,0,0,0);
      ST_WB_I:     return mk(0,1,0,0,2'd0,0,0,0,2'd0,2'd0,0,0,0);
      ST_MEM_ADDR: return mk(0,0,0,1,2'd2,0,0,0,2'd0,2'd0,0,0,0);
      ST_WB_M:     return mk(0,1,0,0,2'd0,0,1,0,2'd0,2'd0,0,0,0);
      ST_MEM_WR:   return mk(0,0,0,0,2'd0,1,0,0,2'd0,2'd0,0,0,0);
      ST_BRANCH:   return mk(0,0,0,1,2'd0,0,0,1,2'd1,2'd1,0,0,0);
      ST_JUMP:     return mk(0,0,0,0,2'd0,0,0,0,2'd2,2'd0,1,0,0);
      ST_ERROR:    return mk(0,0,0,0,2'd0,0,0,0,2'd0,2'd0,0,0,1);
      default:     return 16'h0000;   // IDLE, MEM_RD
    endcase
  endfunction

  typedef struct {
    string      name;
    logic [5:0] op;
    int         ready_low;  // cycles mem_ready stays 0 in MEM_RD/MEM_WR
    int         lat;        // FETCH to next FETCH
    int         regw;       // cycles with RegWrite=1
    int         memw;       // cycles with MemWrite=1
    int         m2r;        // cycles with MemtoReg=1
    int         pcw;        // cycles with pc_write=1
  } vec_t;

  vec_t vecs[8];

  // Entry: at a negedge with the DUT in FETCH. Exit: at the negedge of the next FETCH/ERROR.
  task automatic run_vec(input vec_t v);
    int cyc, regw, memw, m2r, pcw, mwait;
    bit done;
    logic [15:0] c0;
    c0 = bus.instr_count;
    bus.opcode = v.op;
    bus.mem_ready = 1'b0;
    chk({v.name, " fetch ctrl"}, 32'(outs()), 32'(exp_ctrl(ST_FETCH)));
    cyc = 1; regw = int'(bus.RegWrite); memw = int'(bus.MemWrite);
    m2r = int'(bus.MemtoReg); pcw = int'(bus.pc_write);
    mwait = 0; done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (bus.state == ST_FETCH || bus.state == ST_ERROR) begin
        done = 1'b1;
      end else begin
        cyc++;
        regw += int'(bus.RegWrite);
        memw += int'(bus.MemWrite);
        m2r  += int'(bus.MemtoReg);
        pcw  += int'(bus.pc_write);
        chk($sformatf("%s ctrl st%0d", v.name, bus.state), 32'(outs()), 32'(exp_ctrl(bus.state)));
        if (bus.state == ST_MEM_RD || bus.state == ST_MEM_WR) begin
          bus.mem_ready = (mwait >= v.ready_low);
          mwait++;
        end else begin
          bus.mem_ready = 1'b0;
        end
      end
    end
    bus.mem_ready = 1'b0;
    chk({v.name, " end state"}, 32'(bus.state), 32'(ST_FETCH));
    chk({v.name, " latency"},   32'(cyc),  32'(v.lat));
    chk({v.name, " RegWrite"},  32'(regw), 32'(v.regw));
    chk({v.name, " MemWrite"},  32'(memw), 32'(v.memw));
    chk({v.name, " MemtoReg"},  32'(m2r),  32'(v.m2r));
    chk({v.name, " pc_write"},  32'(pcw),  32'(v.pcw));
    chk({v.name, " count"},     32'(bus.instr_count), 32'(16'(c0 + 16'd1)));
  endtask

  task automatic reset_seq(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk({name, " rst state"}, 32'(bus.state), 32'(ST_IDLE));
    chk({name, " rst count"}, 32'(bus.instr_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk({name, " idle"}, 32'(bus.state), 32'(ST_IDLE));
    @(negedge clk);
    chk({name, " fetch"}, 32'(bus.state), 32'(ST_FETCH));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c0;
    int n;
    bit hit;

    vecs[0] = '{"R",     6'b000000, 0, 4, 1, 0, 0, 1};
    vecs[1] = '{"ADDI",  6'b001000, 0, 4, 1, 0, 0, 1};
    vecs[2] = '{"LW_w3", 6'b100011, 3, 8, 1, 0, 1, 1};
    vecs[3] = '{"LW_w0", 6'b100011, 0, 5, 1, 0, 1, 1};
    vecs[4] = '{"SW_w0", 6'b101011, 0, 4, 0, 1, 0, 1};
    vecs[5] = '{"SW_w2", 6'b101011, 2, 6, 0, 3, 0, 1};
    vecs[6] = '{"BEQ",   6'b000100, 0, 3, 0, 0, 0, 1};
    vecs[7] = '{"J",     6'b000010, 0, 3, 0, 0, 0, 2};

    rst_n = 1'b0; rst2_n = 1'b0;
    bus.opcode = 6'd0;   bus.mem_ready = 1'b0;
    bus2.opcode = OP_J;  bus2.mem_ready = 1'b0;
    repeat (2) @(negedge clk);

    chk("reset state", 32'(bus.state), 32'(ST_IDLE));
    chk("reset outs",  32'(outs()), 32'd0);
    chk("reset count", 32'(bus.instr_count), 32'd0);

    // Counter wrap on the 4-bit instance running back-to-back jumps
    rst2_n = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 300 && !hit; k++) begin
      @(negedge clk);
      if (bus2.instr_count == 4'hF) hit = 1'b1;
    end
    chk("wrap reach max", 32'(hit), 32'd1);
    hit = 1'b0;
    for (int k = 0; k < 10 && !hit; k++) begin
      @(negedge clk);
      if (bus2.instr_count != 4'hF) hit = 1'b1;
    end
    chk("wrap to zero", 32'(bus2.instr_count), 32'd0);

    // Test 1: reset release and one R-type with explicit state walk
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t1 idle", 32'(bus.state), 32'(ST_IDLE));
    chk("t1 idle outs", 32'(outs()), 32'd0);
    @(negedge clk);
    chk("t1 fetch", 32'(bus.state), 32'(ST_FETCH));
    chk("t1 no count from idle", 32'(bus.instr_count), 32'd0);
    bus.opcode = OP_R;
    @(negedge clk);
    chk("t1 decode", 32'(bus.state), 32'(ST_DECODE));
    chk("t1 decode regwrite", 32'(bus.RegWrite), 32'd0);
    @(negedge clk);
    chk("t1 exec_r", 32'(bus.state), 32'(ST_EXEC_R));
    chk("t1 exec_r regwrite", 32'(bus.RegWrite), 32'd0);
    @(negedge clk);
    chk("t1 wb_r", 32'(bus.state), 32'(ST_WB_R));
    chk("t1 wb_r regwrite/regdst", 32'({bus.RegWrite, bus.RegDst}), 32'd3);
    @(negedge clk);
    chk("t1 fetch again", 32'(bus.state), 32'(ST_FETCH));
    chk("t1 count", 32'(bus.instr_count), 32'd1);

    // Table of instruction classes
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);
    chk("table count", 32'(bus.instr_count), 32'd9);

    // Test 5a: unknown opcode
    c0 = bus.instr_count;
    bus.opcode = 6'b111111;
    @(negedge clk);
    chk("t5 decode", 32'(bus.state), 32'(ST_DECODE));
    @(negedge clk);
    chk("t5 error", 32'(bus.state), 32'(ST_ERROR));
    chk("t5 error outs", 32'(outs()), 32'(exp_ctrl(ST_ERROR)));
    repeat (5) @(negedge clk);
    chk("t5 error sticky", 32'(bus.state), 32'(ST_ERROR));
    chk("t5 illegal", 32'(bus.illegal), 32'd1);
    chk("t5 count frozen", 32'(bus.instr_count), 32'(c0));
    reset_seq("t5a");

    // Test 5b: SW with memory never ready
    bus.opcode = OP_SW;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5b mem_addr", 32'(bus.state), 32'(ST_MEM_ADDR));
    n = 0;
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      if (bus.state == ST_MEM_WR) n++;
      else hit = 1'b1;
    end
    chk("t5b wait cycles", 32'(n), 32'd15);
    chk("t5b error", 32'(bus.state), 32'(ST_ERROR));
    chk("t5b illegal", 32'(bus.illegal), 32'd1);
    chk("t5b memwrite off", 32'(bus.MemWrite), 32'd0);
    reset_seq("t5b");

    // Test 5c: mem_ready on the last tolerated cycle completes normally
    bus.opcode = OP_SW;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t5c mem_wr", 32'(bus.state), 32'(ST_MEM_WR));
    repeat (14) @(negedge clk);
    chk("t5c still mem_wr", 32'(bus.state), 32'(ST_MEM_WR));
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    chk("t5c fetch", 32'(bus.state), 32'(ST_FETCH));
    chk("t5c no illegal", 32'(bus.illegal), 32'd0);
    chk("t5c count", 32'(bus.instr_count), 32'd1);

    // Test 6: async reset in MEM_WR
    bus.opcode = OP_SW;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t6 mem_wr", 32'(bus.state), 32'(ST_MEM_WR));
    chk("t6 memwrite on", 32'(bus.MemWrite), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 memwrite async drop", 32'(bus.MemWrite), 32'd0);
    chk("t6 idle", 32'(bus.state), 32'(ST_IDLE));
    chk("t6 count cleared", 32'(bus.instr_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6 recover idle", 32'(bus.state), 32'(ST_IDLE));
    @(negedge clk);
    chk("t6 recover fetch", 32'(bus.state), 32'(ST_FETCH));
    run_vec(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
